// File: rtl/cpu_fetch.sv
// ============================================================================
//  Module   : cpu_fetch
//  Purpose  : RV32 multi-cycle instruction fetch stage; holds the PC, reads one
//             word per instruction and hands it to decode with a 1-cycle strobe.
//  Options  : CPU_FETCH_TIMEOUT_EN adds a bus-wait timeout with sticky fault.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cpu_fetch #(
   parameter logic [31:0] RESET_PC       = 32'h0000_0000,
   parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
   input  logic        i_clock,
   input  logic        i_reset,
   output logic        o_bus_request,
   output logic [31:0] o_bus_address,
   input  logic        i_bus_ready,
   input  logic [31:0] i_bus_rdata,
   output logic [31:0] o_instruction,
   output logic [31:0] o_pc,
   output logic        o_fetched,
   input  logic        i_next,
   input  logic        i_branch,
   input  logic [31:0] i_branch_pc,
   output logic        o_fault
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ       = 3'd1,
      S_ISSUE     = 3'd2,
      S_WAIT_NEXT = 3'd3
`ifdef CPU_FETCH_TIMEOUT_EN
      ,S_FAULT    = 3'd4
`endif
   } state_t;

   state_t      r_state,       w_state_nxt;
   logic [31:0] r_pc,          w_pc_nxt;
   logic        r_bus_request, w_bus_request_nxt;
   logic [31:0] r_instruction, w_instruction_nxt;
   logic [31:0] r_out_pc,      w_out_pc_nxt;
   logic        r_fetched,     w_fetched_nxt;
   logic        r_fault,       w_fault_nxt;
`ifdef CPU_FETCH_TIMEOUT_EN
   logic [7:0]  r_wait_cnt,    w_wait_cnt_nxt;
`endif

   // Branch targets are forced word-aligned; the low bits are intentionally dropped.
   logic [31:0] w_branch_target;
   logic        w_unused;
   assign w_branch_target = {i_branch_pc[31:2], 2'b00};
   assign w_unused        = &{1'b0, i_branch_pc[1:0], TIMEOUT_CYCLES[0]};

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         r_state       <= S_IDLE;
         r_pc          <= RESET_PC;
         r_bus_request <= 1'b0;
         r_instruction <= 32'h0000_0000;
         r_out_pc      <= 32'h0000_0000;
         r_fetched     <= 1'b0;
         r_fault       <= 1'b0;
`ifdef CPU_FETCH_TIMEOUT_EN
         r_wait_cnt    <= 8'd0;
`endif
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_bus_request <= w_bus_request_nxt;
         r_instruction <= w_instruction_nxt;
         r_out_pc      <= w_out_pc_nxt;
         r_fetched     <= w_fetched_nxt;
         r_fault       <= w_fault_nxt;
`ifdef CPU_FETCH_TIMEOUT_EN
         r_wait_cnt    <= w_wait_cnt_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_pc_nxt          = r_pc;
      w_bus_request_nxt = r_bus_request;
      w_instruction_nxt = r_instruction;
      w_out_pc_nxt      = r_out_pc;
      w_fetched_nxt     = r_fetched;
      w_fault_nxt       = r_fault;
`ifdef CPU_FETCH_TIMEOUT_EN
      w_wait_cnt_nxt    = r_wait_cnt;
`endif

      case (r_state)
         S_IDLE: begin
            w_state_nxt       = S_REQ;
            w_bus_request_nxt = 1'b1;
`ifdef CPU_FETCH_TIMEOUT_EN
            w_wait_cnt_nxt    = 8'd0;
`endif
         end

         S_REQ: begin
            // A response in the same cycle the timeout is reached still wins.
            if (i_bus_ready) begin
               w_instruction_nxt = i_bus_rdata;
               w_out_pc_nxt      = r_pc;
               w_bus_request_nxt = 1'b0;
               w_fetched_nxt     = 1'b1;
               w_state_nxt       = S_ISSUE;
            end
`ifdef CPU_FETCH_TIMEOUT_EN
            else if (r_wait_cnt == TIMEOUT_CYCLES) begin
               w_bus_request_nxt = 1'b0;
               w_fault_nxt       = 1'b1;
               w_state_nxt       = S_FAULT;
            end else begin
               w_wait_cnt_nxt    = r_wait_cnt + 8'd1;
            end
`endif
         end

         S_ISSUE: begin
            w_fetched_nxt = 1'b0;
            w_state_nxt   = S_WAIT_NEXT;
         end

         S_WAIT_NEXT: begin
            if (i_next) begin
               w_pc_nxt          = i_branch ? w_branch_target : r_pc + 32'd4;
               w_bus_request_nxt = 1'b1;
               w_state_nxt       = S_REQ;
`ifdef CPU_FETCH_TIMEOUT_EN
               w_wait_cnt_nxt    = 8'd0;
`endif
            end
         end

`ifdef CPU_FETCH_TIMEOUT_EN
         S_FAULT: begin
            w_state_nxt = S_FAULT;
         end
`endif

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign o_bus_address = r_pc;
   assign o_bus_request = r_bus_request;
   assign o_instruction = r_instruction;
   assign o_pc          = r_out_pc;
   assign o_fetched     = r_fetched;
   assign o_fault       = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_cpu_fetch.sv
// ============================================================================
//  Module   : tb_cpu_fetch
//  Purpose  : Directed self-checking bench for cpu_fetch (both timeout builds).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cpu_fetch;

`ifdef CPU_FETCH_TIMEOUT_EN
   localparam int  WAIT_HOLD = 4;
   localparam bit  TO_EN     = 1'b1;
`else
   localparam int  WAIT_HOLD = 5;
   localparam bit  TO_EN     = 1'b0;
`endif
   localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        o_bus_request;
   logic [31:0] o_bus_address;
   logic        i_bus_ready = 1'b0;
   logic [31:0] i_bus_rdata = 32'h0;
   logic [31:0] o_instruction;
   logic [31:0] o_pc;
   logic        o_fetched;
   logic        i_next = 1'b0;
   logic        i_branch = 1'b0;
   logic [31:0] i_branch_pc = 32'h0;
   logic        o_fault;

   int n_compared   = 0;
   int n_mismatched = 0;

   cpu_fetch #(
      .RESET_PC       (C_RESET_PC),
      .TIMEOUT_CYCLES (8'd4)
   ) dut (
      .i_clock       (i_clock),
      .i_reset       (i_reset),
      .o_bus_request (o_bus_request),
      .o_bus_address (o_bus_address),
      .i_bus_ready   (i_bus_ready),
      .i_bus_rdata   (i_bus_rdata),
      .o_instruction (o_instruction),
      .o_pc          (o_pc),
      .o_fetched     (o_fetched),
      .i_next        (i_next),
      .i_branch      (i_branch),
      .i_branch_pc   (i_branch_pc),
      .o_fault       (o_fault)
   );

   always #5 i_clock = ~i_clock;

   task automatic tick();
      @(posedge i_clock);
      #1;
   endtask

   // Completes the bus read currently pending in REQ and steps through ISSUE.
   task automatic finish_fetch(input logic [31:0] data);
      i_bus_ready = 1'b1; i_bus_rdata = data;
      tick();
      i_bus_ready = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      i_reset = 1'b0;
      tick(); tick();
      n_compared++; if (o_bus_request !== 1'b0) begin n_mismatched++; $display("FAIL reset_req: got %b want 0", o_bus_request); end
      n_compared++; if (o_fetched !== 1'b0) begin n_mismatched++; $display("FAIL reset_fetched: got %b want 0", o_fetched); end
      n_compared++; if (o_instruction !== 32'h0) begin n_mismatched++; $display("FAIL reset_instr: got %h want 0", o_instruction); end
      n_compared++; if (o_pc !== 32'h0) begin n_mismatched++; $display("FAIL reset_pc: got %h want 0", o_pc); end
      n_compared++; if (o_fault !== 1'b0) begin n_mismatched++; $display("FAIL reset_fault: got %b want 0", o_fault); end
      n_compared++; if (o_bus_address !== C_RESET_PC) begin n_mismatched++; $display("FAIL reset_addr: got %h want %h", o_bus_address, C_RESET_PC); end
   endtask

   task automatic test_first_fetch();
      i_reset = 1'b1;
      tick();
      n_compared++; if (o_bus_request !== 1'b1) begin n_mismatched++; $display("FAIL first_req: got %b want 1", o_bus_request); end
      n_compared++; if (o_bus_address !== 32'h0) begin n_mismatched++; $display("FAIL first_addr: got %h want 0", o_bus_address); end
      i_bus_ready = 1'b1; i_bus_rdata = 32'h0000_0013;
      tick();
      i_bus_ready = 1'b0; i_bus_rdata = 32'hDEAD_BEEF;
      n_compared++; if (o_bus_request !== 1'b0) begin n_mismatched++; $display("FAIL first_req_drop: got %b want 0", o_bus_request); end
      n_compared++; if (o_fetched !== 1'b1) begin n_mismatched++; $display("FAIL first_strobe: got %b want 1", o_fetched); end
      n_compared++; if (o_instruction !== 32'h0000_0013) begin n_mismatched++; $display("FAIL first_instr: got %h want 00000013", o_instruction); end
      n_compared++; if (o_pc !== 32'h0) begin n_mismatched++; $display("FAIL first_pc: got %h want 0", o_pc); end
      tick();
      n_compared++; if (o_fetched !== 1'b0) begin n_mismatched++; $display("FAIL first_strobe_len: got %b want 0", o_fetched); end
      n_compared++; if (o_instruction !== 32'h0000_0013) begin n_mismatched++; $display("FAIL first_instr_hold: got %h want 00000013", o_instruction); end
   endtask

   task automatic test_next_and_branch();
      i_branch = 1'b1; i_branch_pc = 32'h0000_0200;
      tick();
      i_branch = 1'b0;
      n_compared++; if (o_bus_request !== 1'b0) begin n_mismatched++; $display("FAIL branch_no_next: got %b want 0", o_bus_request); end
      i_next = 1'b1;
      tick();
      i_next = 1'b0;
      n_compared++; if (o_bus_request !== 1'b1) begin n_mismatched++; $display("FAIL seq_req: got %b want 1", o_bus_request); end
      n_compared++; if (o_bus_address !== 32'h0000_0004) begin n_mismatched++; $display("FAIL seq_addr: got %h want 00000004", o_bus_address); end
      i_bus_ready = 1'b1; i_bus_rdata = 32'h0040_0093;
      tick();
      i_bus_ready = 1'b0;
      n_compared++; if (o_pc !== 32'h0000_0004) begin n_mismatched++; $display("FAIL seq_pc: got %h want 00000004", o_pc); end
      n_compared++; if (o_instruction !== 32'h0040_0093) begin n_mismatched++; $display("FAIL seq_instr: got %h want 00400093", o_instruction); end
      tick();
      i_next = 1'b1; i_branch = 1'b1; i_branch_pc = 32'h0000_0103;
      tick();
      i_next = 1'b0; i_branch = 1'b0;
      n_compared++; if (o_bus_address !== 32'h0000_0100) begin n_mismatched++; $display("FAIL branch_addr: got %h want 00000100", o_bus_address); end
      n_compared++; if (o_bus_request !== 1'b1) begin n_mismatched++; $display("FAIL branch_req: got %b want 1", o_bus_request); end
      finish_fetch(32'h1111_1111);
      n_compared++; if (o_pc !== 32'h0000_0100) begin n_mismatched++; $display("FAIL branch_pc: got %h want 00000100", o_pc); end
   endtask

   task automatic test_wait_states();
      i_next = 1'b1;
      tick();
      for (int k = 0; k < WAIT_HOLD; k++) begin
         i_next = k[0];
         tick();
         n_compared++; if (o_bus_request !== 1'b1) begin n_mismatched++; $display("FAIL wait_req[%0d]: got %b want 1", k, o_bus_request); end
         n_compared++; if (o_bus_address !== 32'h0000_0104) begin n_mismatched++; $display("FAIL wait_addr[%0d]: got %h want 00000104", k, o_bus_address); end
         n_compared++; if (o_fetched !== 1'b0) begin n_mismatched++; $display("FAIL wait_strobe[%0d]: got %b want 0", k, o_fetched); end
      end
      i_next = 1'b0; i_bus_ready = 1'b1; i_bus_rdata = 32'hAAAA_5555;
      tick();
      i_bus_ready = 1'b0;
      n_compared++; if (o_fetched !== 1'b1) begin n_mismatched++; $display("FAIL wait_strobe_end: got %b want 1", o_fetched); end
      n_compared++; if (o_instruction !== 32'hAAAA_5555) begin n_mismatched++; $display("FAIL wait_instr: got %h want aaaa5555", o_instruction); end
      i_next = 1'b1;
      tick();
      i_next = 1'b0;
      n_compared++; if (o_fetched !== 1'b0) begin n_mismatched++; $display("FAIL wait_single_strobe: got %b want 0", o_fetched); end
      n_compared++; if (o_bus_request !== 1'b0) begin n_mismatched++; $display("FAIL next_in_issue: got %b want 0", o_bus_request); end
      tick();
      n_compared++; if (o_bus_request !== 1'b0) begin n_mismatched++; $display("FAIL next_queued: got %b want 0", o_bus_request); end
      n_compared++; if (o_bus_address !== 32'h0000_0104) begin n_mismatched++; $display("FAIL pc_moved: got %h want 00000104", o_bus_address); end
   endtask

   task automatic test_reset_mid_request();
      i_next = 1'b1; i_branch = 1'b1; i_branch_pc = 32'h0000_0008;
      tick();
      i_next = 1'b0; i_branch = 1'b0;
      n_compared++; if (o_bus_address !== 32'h0000_0008) begin n_mismatched++; $display("FAIL midrst_addr: got %h want 00000008", o_bus_address); end
      #2 i_reset = 1'b0;
      #1;
      n_compared++; if (o_bus_request !== 1'b0) begin n_mismatched++; $display("FAIL midrst_req_async: got %b want 0", o_bus_request); end
      n_compared++; if (o_bus_address !== C_RESET_PC) begin n_mismatched++; $display("FAIL midrst_addr_async: got %h want %h", o_bus_address, C_RESET_PC); end
      n_compared++; if (o_instruction !== 32'h0) begin n_mismatched++; $display("FAIL midrst_instr: got %h want 0", o_instruction); end
      tick();
      i_reset = 1'b1;
      tick();
      n_compared++; if (o_bus_request !== 1'b1) begin n_mismatched++; $display("FAIL restart_req: got %b want 1", o_bus_request); end
      n_compared++; if (o_bus_address !== C_RESET_PC) begin n_mismatched++; $display("FAIL restart_addr: got %h want %h", o_bus_address, C_RESET_PC); end
      finish_fetch(32'h0000_0013);
   endtask

   task automatic test_pc_wrap();
      i_next = 1'b1; i_branch = 1'b1; i_branch_pc = 32'hFFFF_FFFC;
      tick();
      i_next = 1'b0; i_branch = 1'b0;
      n_compared++; if (o_bus_address !== 32'hFFFF_FFFC) begin n_mismatched++; $display("FAIL wrap_top_addr: got %h want fffffffc", o_bus_address); end
      finish_fetch(32'h0000_006F);
      n_compared++; if (o_pc !== 32'hFFFF_FFFC) begin n_mismatched++; $display("FAIL wrap_top_pc: got %h want fffffffc", o_pc); end
      i_next = 1'b1;
      tick();
      i_next = 1'b0;
      n_compared++; if (o_bus_address !== 32'h0000_0000) begin n_mismatched++; $display("FAIL wrap_addr: got %h want 00000000", o_bus_address); end
      n_compared++; if (o_bus_request !== 1'b1) begin n_mismatched++; $display("FAIL wrap_req: got %b want 1", o_bus_request); end
      finish_fetch(32'h0000_0013);
   endtask

   task automatic test_timeout();
      logic exp_fault;
      i_next = 1'b1;
      tick();
      i_next = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         exp_fault = TO_EN && (k >= 4);
         n_compared++; if (o_fault !== exp_fault) begin n_mismatched++; $display("FAIL to_fault[%0d]: got %b want %b", k, o_fault, exp_fault); end
         n_compared++; if (o_bus_request !== !exp_fault) begin n_mismatched++; $display("FAIL to_req[%0d]: got %b want %b", k, o_bus_request, !exp_fault); end
      end
`ifdef CPU_FETCH_TIMEOUT_EN
      i_next = 1'b1; i_bus_ready = 1'b1; i_bus_rdata = 32'h1234_5678;
      tick(); tick();
      i_next = 1'b0; i_bus_ready = 1'b0;
      n_compared++; if (o_fault !== 1'b1) begin n_mismatched++; $display("FAIL fault_sticky: got %b want 1", o_fault); end
      n_compared++; if (o_bus_request !== 1'b0) begin n_mismatched++; $display("FAIL fault_req: got %b want 0", o_bus_request); end
      n_compared++; if (o_fetched !== 1'b0) begin n_mismatched++; $display("FAIL fault_strobe: got %b want 0", o_fetched); end
      n_compared++; if (o_instruction === 32'h1234_5678) begin n_mismatched++; $display("FAIL fault_capture: got %h want not 12345678", o_instruction); end
      i_reset = 1'b0;
      #1;
      n_compared++; if (o_fault !== 1'b0) begin n_mismatched++; $display("FAIL fault_clear: got %b want 0", o_fault); end
      tick();
      i_reset = 1'b1;
`else
      i_bus_ready = 1'b1; i_bus_rdata = 32'h1234_5678;
      tick();
      i_bus_ready = 1'b0;
      n_compared++; if (o_instruction !== 32'h1234_5678) begin n_mismatched++; $display("FAIL late_ready_instr: got %h want 12345678", o_instruction); end
      n_compared++; if (o_pc !== 32'h0000_0004) begin n_mismatched++; $display("FAIL late_ready_pc: got %h want 00000004", o_pc); end
`endif
   endtask

   initial begin
      test_reset();
      test_first_fetch();
      test_next_and_branch();
      test_wait_states();
      test_reset_mid_request();
      test_pc_wrap();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/cpu_fetch.md
Name: cpu_fetch

Overview:
- Instruction fetch stage, directly upstream of the decode stage, in the multi-cycle RV32 core.
- Holds the PC and issues one 32-bit instruction read per instruction on the instruction bus.
- Presents the fetched word plus a one-cycle o_fetched strobe, which drives decode's i_decode/i_instruction.
- Waits for the downstream i_next handshake, then advances to PC+4 or a branch target.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset; bits [1:0] must be 0.
TIMEOUT_CYCLES, 255, bus-wait cycles before fault (used only with the optional feature); 8-bit counter, legal range 1..255.

Ports:
i_clock  in  1  clock, all state changes on rising edge
i_reset  in  1  asynchronous, active-low reset
o_bus_request  out  1  instruction read request, held until accepted
o_bus_address  out  32  read address, equals current PC
i_bus_ready  in  1  read data valid / request accepted, sampled only while requesting
i_bus_rdata  in  32  instruction read data
o_instruction  out  32  last fetched instruction, to decode
o_pc  out  32  PC of o_instruction
o_fetched  out  1  one-cycle strobe, to decode i_decode
i_next  in  1  downstream done, fetch next instruction
i_branch  in  1  qualifies i_next: take i_branch_pc instead of PC+4
i_branch_pc  in  32  branch/jump target
o_fault  out  1  sticky bus-timeout fault (constant 0 without the feature)

Behaviour:
- Reset (i_reset=0, async), all values forced immediately:
  - state=IDLE, pc=RESET_PC
  - o_bus_request=0, o_fetched=0, o_instruction=0, o_pc=0, o_fault=0
  - wait counter=0
- A reset mid-transaction aborts it; request drops without waiting for the clock.
- o_bus_address is combinational from the pc register.
- All other outputs are registered.
- States: IDLE, REQ, ISSUE, WAIT_NEXT, FAULT (FAULT exists only with the feature).
- IDLE: unconditional move to REQ on the first edge after reset release; o_bus_request=1 from that edge.
- REQ: o_bus_request held at 1 with a stable address.
  - On an edge with i_bus_ready=1: o_instruction<=i_bus_rdata, o_pc<=pc, o_bus_request<=0, o_fetched<=1, go ISSUE.
  - Zero-wait bus: request high for exactly 1 cycle, o_fetched high on the next cycle.
- ISSUE: o_fetched<=0, go WAIT_NEXT. o_fetched is therefore high for exactly one cycle per fetch.
- WAIT_NEXT: on i_next=1:
  - pc <= i_branch ? {i_branch_pc[31:2],2'b00} : pc+4; 32-bit wrap (32'hFFFFFFFC+4 = 0).
  - o_bus_request<=1, go REQ.
  - Latency: i_next at edge N gives a request with the new address visible after edge N.
- i_next or i_branch in any state other than WAIT_NEXT is ignored; no queueing.
- i_branch without i_next has no effect.
- i_bus_ready outside REQ is ignored.
- o_instruction and o_pc remain stable from the ISSUE cycle until the next accepted bus response.

Optional Feature:
Macro CPU_FETCH_TIMEOUT_EN.
- Defined:
  - 8-bit wait counter clears on REQ entry and increments on every REQ cycle with i_bus_ready=0.
  - When the counter reaches TIMEOUT_CYCLES, the next edge goes to FAULT: o_bus_request<=0, o_fault<=1.
  - FAULT is terminal until reset; i_next and i_bus_ready are ignored there.
  - A response arriving in the same cycle the count is reached wins: normal ISSUE path, no fault.
- Not defined:
  - No counter and no FAULT state.
  - REQ waits indefinitely; o_fault tied 0.

Test Plan:
- Release reset, bus ready on the first request cycle with rdata=32'h00000013 -> o_bus_address=0 and request high 1 cycle, then o_fetched=1 for 1 cycle, o_instruction=32'h00000013, o_pc=0.
- Pulse i_next in WAIT_NEXT without branch -> next request at address 4; then i_next with i_branch=1 and i_branch_pc=32'h00000103 -> request at 32'h00000100.
- Hold i_bus_ready=0 for 5 cycles -> address stable and request held for 6 cycles; single o_fetched; i_next pulses during REQ/ISSUE have no effect.
- Assert reset during REQ at PC=8 -> request drops immediately; after release, fetch restarts at RESET_PC.
- With CPU_FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, bus never ready -> o_fault=1 and request=0 after the count; later i_next and i_bus_ready ignored until reset. Without the macro, same stimulus -> request held, o_fault=0.
- PC wrap: branch to 32'hFFFFFFFC, fetch, i_next -> next request address 32'h00000000.
